// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux stream merger.
package arb_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel-index width, kept at least one bit so single-channel builds still have a port.
  function automatic int unsigned sel_w(input int unsigned chans);
    return (chans > 1) ? $clog2(chans) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: fixed priority from index 0, or round-robin starting at ptr.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = sel_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  logic                mode,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                any_grant
);

  localparam int unsigned SUM_W = SEL_W + 1;

  logic [SEL_W-1:0] start_c;
  logic [SUM_W-1:0] sum_c;
  logic [SEL_W-1:0] idx_c;

  // Walk the channels from the start index with modulo wrap; first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sum_c     = '0;
    idx_c     = '0;
    start_c   = (mode == MODE_RR) ? ptr : '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      sum_c = {1'b0, start_c} + SUM_W'(k);
      if (sum_c >= SUM_W'(CHANNELS)) begin
        sum_c = sum_c - SUM_W'(CHANNELS);
      end
      idx_c = sum_c[SEL_W-1:0];
      if (!any_grant && req[idx_c]) begin
        grant[idx_c] = 1'b1;
        grant_idx    = idx_c;
        any_grant    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Merges CHANNELS valid/ready streams into one registered output stream.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = sel_w(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready,
  output logic [N-1:0]          out_data,
  output logic [SEL_W-1:0]      out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic                load_en_c;
  logic                in_xfer_c;
  logic [CHANNELS-1:0] grant_c;
  logic [SEL_W-1:0]    grant_idx_c;
  logic                any_grant_c;
  logic [SEL_W-1:0]    next_ptr_c;
  logic [SEL_W-1:0]    ptr_q;
  logic [N-1:0]        chan_data_c [CHANNELS];

  // Unpack the flat input bus into per-channel words.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign chan_data_c[i] = in_data[i*N +: N];
  end

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .mode      (mode),
    .grant     (grant_c),
    .grant_idx (grant_idx_c),
    .any_grant (any_grant_c)
  );

  // Output register may load when empty or being drained this cycle.
  assign load_en_c  = !out_valid || out_ready;
  assign in_ready   = grant_c & {CHANNELS{load_en_c}};
  assign in_xfer_c  = any_grant_c && load_en_c;
  assign next_ptr_c = (grant_idx_c == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx_c + SEL_W'(1);

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr_q     <= '0;
    end else if (load_en_c) begin
      out_valid <= any_grant_c;
      if (in_xfer_c) begin
        out_data <= chan_data_c[grant_idx_c];
        out_chan <= grant_idx_c;
        if (mode == MODE_RR) begin
          ptr_q <= next_ptr_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: 4-channel main instance plus a 3-channel wrap instance.
module tb_arb_mux;
  import arb_mux_pkg::*;

  localparam int unsigned N  = 32;
  localparam int unsigned CH = 4;

  typedef struct packed {
    logic [1:0]  chan;
    logic [31:0] data;
  } sb_item_t;

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0] in_valid;
  logic [CH-1:0] in_ready;
  logic [N-1:0]  out_data;
  logic [1:0]    out_chan;
  logic          out_valid;
  logic          out_ready;

  logic          mode3;
  logic [3*N-1:0] in_data3;
  logic [2:0]    in_valid3;
  logic [2:0]    in_ready3;
  logic [N-1:0]  out_data3;
  logic [1:0]    out_chan3;
  logic          out_valid3;
  logic          out_ready3;

  arb_mux #(.N(N), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  arb_mux #(.N(N), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  int          n_checks;
  int          n_fails;
  sb_item_t    sb_q[$];
  int          m_ptr;
  logic        m_vld;
  logic [31:0] m_data;
  logic [1:0]  m_chan;
  logic [31:0] ch_data [CH];
  logic        auto_data;
  int          seq;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v, input logic md, input int p, input int nch);
    int s;
    int i;
    s = (md == MODE_RR) ? p : 0;
    for (int k = 0; k < nch; k++) begin
      i = (s + k) % nch;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic pack_data();
    for (int i = 0; i < CH; i++) in_data[i*N +: N] = ch_data[i];
  endtask

  // One clock of stimulus starting and ending at a falling edge.
  task automatic cycle(input logic [3:0] v, input logic rdy, input logic md);
    int       g;
    logic     ld;
    logic [3:0] er;
    sb_item_t it;
    in_valid  = v;
    out_ready = rdy;
    mode      = md;
    #1;
    g  = model_grant(v, md, m_ptr, CH);
    ld = !m_vld || rdy;
    er = (g >= 0 && ld) ? 4'(1 << g) : 4'b0;
    check("in_ready", 64'(in_ready), 64'(er));
    if (er != 4'b0) sb_q.push_back('{chan: 2'(g), data: ch_data[g]});
    @(posedge clk);
    if (ld) m_vld = (g >= 0);
    if (er != 4'b0 && md == MODE_RR) m_ptr = (g + 1) % CH;
    #1;
    if (er != 4'b0) begin
      it     = sb_q.pop_front();
      m_data = it.data;
      m_chan = it.chan;
      if (auto_data) begin
        seq++;
        ch_data[g] = {8'(g), 24'(seq)};
        pack_data();
      end
    end
    check("out_valid", 64'(out_valid), 64'(m_vld));
    check("out_data",  64'(out_data),  64'(m_data));
    check("out_chan",  64'(out_chan),  64'(m_chan));
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_vld  = 1'b0;
    m_data = '0;
    m_chan = '0;
    sb_q.delete();
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    seq        = 0;
    auto_data  = 1'b1;
    rst_n      = 1'b0;
    mode       = MODE_RR;
    in_valid   = '0;
    out_ready  = 1'b1;
    mode3      = MODE_RR;
    in_valid3  = '0;
    out_ready3 = 1'b1;
    in_data3   = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
    for (int i = 0; i < CH; i++) ch_data[i] = {8'(i), 24'h0};
    pack_data();
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data",  64'(out_data),  64'(0));
    check("rst_out_chan",  64'(out_chan),  64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(0));
    check("rst_out_valid3", 64'(out_valid3), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin with all channels valid
    for (int k = 0; k < 8; k++) begin
      cycle(4'hF, 1'b1, MODE_RR);
      check("rr_seq", 64'(out_chan), 64'(k % 4));
    end

    // Backpressure then release
    for (int k = 0; k < 5; k++) cycle(4'hF, 1'b0, MODE_RR);
    cycle(4'hF, 1'b1, MODE_RR);
    check("bp_release_valid", 64'(out_valid), 64'(1));
    cycle(4'hF, 1'b1, MODE_RR);
    cycle(4'h0, 1'b1, MODE_RR);
    check("drain_valid", 64'(out_valid), 64'(0));

    // Empty register loads even when consumer is not ready
    cycle(4'hF, 1'b0, MODE_RR);
    cycle(4'hF, 1'b0, MODE_RR);
    cycle(4'h0, 1'b1, MODE_RR);

    // Fixed priority starves channel 3
    auto_data  = 1'b0;
    ch_data[1] = 32'h1111_1111;
    ch_data[3] = 32'h3333_3333;
    pack_data();
    for (int k = 0; k < 6; k++) begin
      cycle(4'b1010, 1'b1, MODE_FIXED);
      check("fixed_chan", 64'(out_chan), 64'(1));
      check("fixed_data", 64'(out_data), 64'h1111_1111);
    end
    auto_data = 1'b1;

    // Mode switch with ptr parked at 2
    cycle(4'b0010, 1'b1, MODE_RR);
    cycle(4'b0101, 1'b1, MODE_FIXED);
    check("switch_fixed_chan", 64'(out_chan), 64'(0));
    cycle(4'b0101, 1'b1, MODE_RR);
    check("switch_rr_chan", 64'(out_chan), 64'(2));

    // Asynchronous reset mid-stream
    cycle(4'hF, 1'b1, MODE_RR);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_data",  64'(out_data),  64'(0));
    check("midrst_out_chan",  64'(out_chan),  64'(0));
    in_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(4'b0110, 1'b1, MODE_RR);
    check("postrst_first_chan", 64'(out_chan), 64'(1));
    cycle(4'b0110, 1'b1, MODE_RR);
    check("postrst_second_chan", 64'(out_chan), 64'(2));
    cycle(4'h0, 1'b1, MODE_RR);

    // Three-channel wrap
    in_valid3 = 3'b010;
    #1 check("wrap_rdy_a", 64'(in_ready3), 64'(3'b010));
    @(posedge clk); #1;
    check("wrap_chan_a", 64'(out_chan3), 64'(1));
    check("wrap_data_a", 64'(out_data3), 64'h0000_00A1);
    @(negedge clk);
    in_valid3 = 3'b101;
    #1 check("wrap_rdy_b", 64'(in_ready3), 64'(3'b100));
    @(posedge clk); #1;
    check("wrap_chan_b", 64'(out_chan3), 64'(2));
    check("wrap_data_b", 64'(out_data3), 64'h0000_00A2);
    @(negedge clk);
    #1 check("wrap_rdy_c", 64'(in_ready3), 64'(3'b001));
    @(posedge clk); #1;
    check("wrap_chan_c", 64'(out_chan3), 64'(0));
    check("wrap_data_c", 64'(out_data3), 64'h0000_00A0);
    check("wrap_valid_c", 64'(out_valid3), 64'(1));
    @(negedge clk);
    #1 check("wrap_rdy_d", 64'(in_ready3), 64'(3'b100));
    @(posedge clk); #1;
    check("wrap_chan_d", 64'(out_chan3), 64'(2));
    @(negedge clk);
    in_valid3 = 3'b000;
    @(posedge clk); #1;
    check("wrap_drain_valid", 64'(out_valid3), 64'(0));
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
